// File: rtl/pc_fetch_sequencer_if.sv
// pc_fetch_sequencer_if: groups the instruction-memory fetch bus and the
// decode-side presentation/redirect signals of the PC fetch sequencer.
//
// Handshakes:
//   imem side   - imem_req is held high with imem_addr stable until a cycle
//                 in which imem_ack is also high; that edge completes the
//                 fetch and imem_rdata is taken. imem_ack with imem_req low
//                 carries no meaning.
//   decode side - instr_valid acts as valid and !stall as ready; an
//                 instruction is consumed on an edge where
//                 instr_valid && !stall. Redirect inputs are meaningful only
//                 in that cycle.
interface pc_fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        stall;
  logic        jump;
  logic [25:0] jump_index;
  logic        branch;
  logic [15:0] branch_offset;
  logic        jr;
  logic [31:0] jr_target;
  logic        misalign;
  // Debug view of the fetch FSM: 0 = FETCH, 1 = PRESENT.
  logic        fsm_state;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, misalign,
           fsm_state,
    input  imem_ack, imem_rdata, stall, jump, jump_index, branch,
           branch_offset, jr, jr_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, misalign,
           fsm_state,
    output imem_ack, imem_rdata, stall, jump, jump_index, branch,
           branch_offset, jr, jr_target
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the PC, issues one instruction fetch at a time
// over a req/ack bus and presents each fetched word to decode. Next-PC is
// built here from sequential, branch, jump-index and jump-register sources.
//
// Optional feature macro: PC_DELAY_SLOT_EN -- MIPS branch delay slot. A
// redirect taken on one instruction is parked in a pending register and
// applied when the following (slot) instruction is consumed.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst_n,
  pc_fetch_sequencer_if.master bus
);

  typedef enum logic {
    FETCH   = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        req_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        misalign_q;

`ifdef PC_DELAY_SLOT_EN
  logic        pend_valid;
  logic [31:0] pend_target;
  logic        redirect_any;
`endif

  logic [31:0] pc4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] jr_addr;
  logic [31:0] redirect_target;
  logic [31:0] next_pc;
  logic        accept;
  logic        consume;
  logic        misalign_set;

  // Candidate targets and the selected next-PC for the presented instruction.
  always_comb begin
    pc4       = instr_pc_q + 32'd4;
    br_target = pc4 + {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
    j_target  = {pc4[31:28], bus.jump_index, 2'b00};
    jr_addr   = {bus.jr_target[31:2], 2'b00};

    if (bus.jr)          redirect_target = jr_addr;
    else if (bus.jump)   redirect_target = j_target;
    else if (bus.branch) redirect_target = br_target;
    else                 redirect_target = pc4;

    accept  = (state == FETCH) && req_q && bus.imem_ack;
    consume = (state == PRESENT) && valid_q && !bus.stall;

`ifdef PC_DELAY_SLOT_EN
    redirect_any = bus.jr || bus.jump || bus.branch;
    // The slot instruction ignores its own redirect inputs and takes the
    // parked target; otherwise any redirect is parked and P+4 is fetched.
    if (pend_valid) begin
      next_pc      = pend_target;
      misalign_set = 1'b0;
    end else begin
      next_pc      = pc4;
      misalign_set = bus.jr && (bus.jr_target[1:0] != 2'b00);
    end
`else
    next_pc      = redirect_target;
    misalign_set = bus.jr && (bus.jr_target[1:0] != 2'b00);
`endif
  end

  // Fetch/present FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      misalign_q <= 1'b0;
`ifdef PC_DELAY_SLOT_EN
      pend_valid  <= 1'b0;
      pend_target <= 32'h0;
`endif
    end else begin
      misalign_q <= 1'b0;
      case (state)
        FETCH: begin
          if (accept) begin
            instr_q    <= bus.imem_rdata;
            instr_pc_q <= pc;
            valid_q    <= 1'b1;
            req_q      <= 1'b0;
            state      <= PRESENT;
          end else begin
            // Covers the first cycle after reset, where req is still low.
            req_q <= 1'b1;
          end
        end
        PRESENT: begin
          if (consume) begin
            pc         <= next_pc;
            valid_q    <= 1'b0;
            req_q      <= 1'b1;
            misalign_q <= misalign_set;
            state      <= FETCH;
`ifdef PC_DELAY_SLOT_EN
            if (pend_valid) begin
              pend_valid <= 1'b0;
            end else if (redirect_any) begin
              pend_valid  <= 1'b1;
              pend_target <= redirect_target;
            end
`endif
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.misalign    = misalign_q;
  assign bus.fsm_state   = state;

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Program-counter and instruction-fetch sequencer for the MIPS datapath. Owns the PC register, issues one fetch at a time to instruction memory with a req/ack handshake, and presents each fetched instruction to decode. It builds the full 32-bit next-PC from sequential, branch, jump-register and 26-bit jump-index sources, forming the `{PC+4[31:28], index, 2'b00}` jump target on its own side rather than zero-extending a 28-bit field downstream.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC of the first fetch after reset; must be word aligned.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request; held high until `imem_ack`.
- `imem_addr`  out  32  fetch address, equal to the PC; stable while `imem_req` is high.
- `imem_ack`  in  1  fetch complete; may assert in the same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction word; valid when `imem_ack` is high.
- `instr_valid`  out  1  `instr` and `instr_pc` hold an unconsumed instruction.
- `instr`  out  32  presented instruction word.
- `instr_pc`  out  32  address of the presented instruction.
- `stall`  in  1  decode cannot accept; blocks consumption.
- `jump`  in  1  redirect to the jump-index target.
- `jump_index`  in  26  J-type index field.
- `branch`  in  1  taken branch.
- `branch_offset`  in  16  signed word offset.
- `jr`  in  1  redirect to register target.
- `jr_target`  in  32  register target address.
- `misalign`  out  1  one-cycle pulse when `jr_target[1:0]` is non-zero on an accepted `jr`.

## Operation
- The FSM has two states.
  - FETCH: `imem_req`=1. When `imem_ack` is seen, latch `imem_rdata` into `instr` and the PC into `instr_pc`, then go to PRESENT.
  - PRESENT: `imem_req`=0, `instr_valid`=1. Consumption happens on `instr_valid && !stall`; it loads the PC with next-PC and returns to FETCH.
- Redirect inputs are sampled only in the consume cycle; they are ignored at all other times.
- Next-PC priority: `jr` > `jump` > `branch` > sequential.
  - Sequential: `pc4 = instr_pc + 4`, mod 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
  - Jump: `{pc4[31:28], jump_index, 2'b00}`.
  - Branch: `pc4 + {{14{branch_offset[15]}}, branch_offset, 2'b00}`, mod 2^32.
  - JR: `{jr_target[31:2], 2'b00}`. If `jr_target[1:0]` is non-zero, pulse `misalign` in the cycle after consumption.
- Reset values: PC=`RESET_PC`, state=FETCH, `imem_req`=1 on the first clock edge after `rst_n` deasserts (0 while `rst_n` is low), `instr_valid`=0, `instr`=0, `instr_pc`=0, `misalign`=0, delay-slot state cleared.
- Reset mid-operation: all state clears immediately. An `imem_ack` arriving while `rst_n` is low is discarded.
- `imem_ack` outside FETCH is ignored.

## Timing
- `imem_ack` arriving in the cycle `imem_req` rises gives `instr_valid` high on the next edge.
- With zero-wait memory and no stall, the sequencer issues one instruction every 2 cycles.
- `imem_addr` updates on the consume edge. `imem_req` rises in the cycle following consumption.
- A stall holds `instr`, `instr_pc` and `instr_valid` unchanged for any number of cycles.

## Configuration
- `PC_DELAY_SLOT_EN` defined: MIPS branch delay slot.
  - A redirect accepted on the instruction at P latches the target into a pending register. The next fetch is P+4, the slot instruction.
  - When the slot instruction is consumed, next-PC is the pending target. Redirect inputs asserted on the slot instruction are ignored.
- `PC_DELAY_SLOT_EN` undefined: the redirect target is the very next fetch. No pending register exists.

## Test plan
- Reset, zero-wait ack, no stall: `imem_addr` sequence 0x0, 0x4, 0x8; `instr_valid` high every second cycle; `instr_pc` tracks the address.
- `instr_pc`=0x1000_0040 with `jump`=1, `jump_index`=26'h000_0100: next `imem_addr`=0x1000_0400. With the macro defined: 0x1000_0044 first, then 0x1000_0400.
- `instr_pc`=0x0000_0100 with `branch`=1, `branch_offset`=16'hFFFE: target 0x0000_00FC. With `jr`=1 and `jr_target`=0x0000_2003 asserted together: address 0x0000_2000 and `misalign` pulse.
- Stall for 5 cycles while PRESENT, and `imem_ack` delayed 3 cycles in FETCH: `instr`, `instr_pc` and `imem_addr` are all held stable; no fetch is duplicated or lost.
- `RESET_PC`=0xFFFF_FFFC, sequential consume: next `imem_addr`=0x0000_0000.
- `rst_n` asserted low while FETCH waits on ack, with ack arriving during reset: ack is discarded; after release, the first fetch is at `RESET_PC` and `instr_valid` stays 0 until the new ack.
